// File: rtl/fp_diff_accumulator_pkg.sv
// Shared types and saturation-limit helpers for the fixed-point difference accumulator.
package fp_diff_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Two's-complement limits of a signed field 'width' bits wide, in a 64-bit container.
    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fp_sat_convert.sv
// Converts a WIA.WF accumulator value to WIO.WFO: floor truncation, or round half-up when
// FP_ACC_ROUND_EN is defined, followed by saturation with a clamp flag.
module fp_sat_convert
    import fp_diff_accumulator_pkg::*;
#(
    parameter int WIA = 9,
    parameter int WF  = 4,
    parameter int WIO = 6,
    parameter int WFO = 2
) (
    input  logic signed [WIA+WF-1:0]   acc_val,
    output logic        [WIO+WFO-1:0]  conv_data,
    output logic                       conv_sat
);

    localparam int WA   = WIA + WF;
    localparam int WO   = WIO + WFO;
    localparam int DROP = WF - WFO;
    localparam logic signed [63:0] OUT_MAX = sat_max(WO);
    localparam logic signed [63:0] OUT_MIN = sat_min(WO);
`ifdef FP_ACC_ROUND_EN
    localparam logic signed [63:0] HALF_LSB = (64'sd1 <<< DROP) >>> 1;
`endif

    logic signed [63:0] wide;
    logic signed [63:0] shifted;

    // NOTE: every output of this always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        wide = {{(64-WA){acc_val[WA-1]}}, acc_val};
`ifdef FP_ACC_ROUND_EN
        wide = wide + HALF_LSB;
`endif
        shifted   = wide >>> DROP;
        conv_data = shifted[WO-1:0];
        conv_sat  = 1'b0;
        if (shifted > OUT_MAX) begin
            conv_data = OUT_MAX[WO-1:0];
            conv_sat  = 1'b1;
        end else if (shifted < OUT_MIN) begin
            conv_data = OUT_MIN[WO-1:0];
            conv_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fp_diff_accumulator.sv
// Accumulates NSAMP signed difference samples per frame into a saturating WIA.WF sum and
// hands the converted WIO.WFO result downstream; FP_ACC_ROUND_EN selects rounding conversion.
module fp_diff_accumulator
    import fp_diff_accumulator_pkg::*;
#(
    parameter int WI    = 5,
    parameter int WF    = 4,
    parameter int WIA   = 9,
    parameter int NSAMP = 16,
    parameter int WIO   = 6,
    parameter int WFO   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI+WF-1:0]     in_data,
    input  logic                 in_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIO+WFO-1:0]   out_data,
    output logic                 out_sat,
    output logic                 out_ovf
);

    localparam int WD  = WI + WF;
    localparam int WA  = WIA + WF;
    localparam int WO  = WIO + WFO;
    localparam int EXT = WA + 1 - WD;
    localparam int CW  = $clog2(NSAMP);
    localparam logic [CW-1:0]      LAST      = CW'(NSAMP - 1);
    localparam logic signed [63:0] ACC_MAX64 = sat_max(WA);
    localparam logic signed [63:0] ACC_MIN64 = sat_min(WA);
    localparam logic [WA-1:0]      ACC_MAX   = ACC_MAX64[WA-1:0];
    localparam logic [WA-1:0]      ACC_MIN   = ACC_MIN64[WA-1:0];

    state_t                state;
    logic signed [WA-1:0]  acc;
    logic signed [WA-1:0]  acc_nxt;
    logic signed [WA:0]    sum;
    logic [CW-1:0]         cnt;
    logic                  sat_st;
    logic                  ovf_st;
    logic                  accept;
    logic                  add_ovf;
    logic [WO-1:0]         conv_data;
    logic                  conv_sat;

    // One guard bit on the sum exposes signed overflow as a mismatch of the top two bits.
    always_comb begin
        accept  = in_valid && in_ready;
        sum     = {acc[WA-1], acc} + {{EXT{in_data[WD-1]}}, in_data};
        add_ovf = sum[WA] ^ sum[WA-1];
        acc_nxt = sum[WA-1:0];
        if (add_ovf) begin
            acc_nxt = sum[WA] ? ACC_MIN : ACC_MAX;
        end
    end

    // The converter sees the post-add value so the result is ready on the final accept edge.
    fp_sat_convert #(
        .WIA (WIA),
        .WF  (WF),
        .WIO (WIO),
        .WFO (WFO)
    ) u_conv (
        .acc_val   (acc_nxt),
        .conv_data (conv_data),
        .conv_sat  (conv_sat)
    );

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat_st    <= 1'b0;
            ovf_st    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        acc    <= acc_nxt;
                        sat_st <= sat_st | add_ovf;
                        ovf_st <= ovf_st | in_ovf;
                        if (cnt == LAST) begin
                            state     <= ST_OUT;
                            cnt       <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= conv_data;
                            out_sat   <= sat_st | add_ovf | conv_sat;
                            out_ovf   <= ovf_st | in_ovf;
                        end else begin
                            state <= ST_ACC;
                            cnt   <= cnt + CW'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        sat_st    <= 1'b0;
                        ovf_st    <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_sat   <= 1'b0;
                        out_ovf   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_diff_accumulator.sv
// Directed bench for fp_diff_accumulator at default parameters; expected values follow FP_ACC_ROUND_EN.
module tb_fp_diff_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic       in_ovf;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sat;
    logic       out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    fp_diff_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [8:0] first;
        logic [8:0] rest;
        logic [7:0] data;
        logic       sat;
    } vec_t;

`ifdef FP_ACC_ROUND_EN
    localparam logic [7:0] POS_EIGHTH = 8'h01;
    localparam logic [7:0] NEG_EIGHTH = 8'h00;
    localparam logic       TIE_SAT    = 1'b1;
`else
    localparam logic [7:0] POS_EIGHTH = 8'h00;
    localparam logic [7:0] NEG_EIGHTH = 8'hFF;
    localparam logic       TIE_SAT    = 1'b0;
`endif

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sixteen back-to-back samples; returns at the negedge after the final accept edge.
    task automatic send_frame(input logic [8:0] first, input logic [8:0] rest, input int ovf_idx);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) check("no_early_valid", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = (i == 0) ? first : rest;
            in_ovf   = (i == ovf_idx);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_ovf   = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [7:0] data, input logic sat,
                                input logic ovf);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"},  32'(out_data),  32'(data));
        check({name, "_sat"},   32'(out_sat),   32'(sat));
        check({name, "_ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_released"}, 32'(out_valid), 32'd0);
        check({name, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{9'h010, 9'h010, 8'h40, 1'b0};
        vecs[1] = '{9'h1E0, 9'h1E0, 8'h80, 1'b0};
        vecs[2] = '{9'h028, 9'h028, 8'h7F, 1'b1};
        vecs[3] = '{9'h002, 9'h000, POS_EIGHTH, 1'b0};
        vecs[4] = '{9'h1FE, 9'h000, NEG_EIGHTH, 1'b0};
        vecs[5] = '{9'h100, 9'h100, 8'h80, 1'b1};
        vecs[6] = '{9'h0FF, 9'h0FF, 8'h7F, 1'b1};
        vecs[7] = '{9'h1F8, 9'h1F8, 8'hE0, 1'b0};
        vecs[8] = '{9'h00D, 9'h021, 8'h7F, 1'b0};
        vecs[9] = '{9'h010, 9'h021, 8'h7F, TIE_SAT};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_sat",   32'(out_sat),   32'd0);
        check("rst_ovf",   32'(out_ovf),   32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].first, vecs[v].rest, -1);
            check_result($sformatf("vec%0d", v), vecs[v].data, vecs[v].sat, 1'b0);
            handshake($sformatf("vec%0d", v));
        end

        // Upstream overflow on sample 7, then five cycles of back-pressure with junk offered.
        send_frame(9'h010, 9'h010, 7);
        for (int k = 0; k < 5; k++) begin
            check_result("hold", 8'h40, 1'b0, 1'b1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            in_data  = 9'h0FF;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_result("hold_last", 8'h40, 1'b0, 1'b1);
        handshake("hold");
        send_frame(9'h010, 9'h010, -1);
        check_result("after_hold", 8'h40, 1'b0, 1'b0);
        handshake("after_hold");

        // Abort mid-frame: clr coincides with the ninth offered sample.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 9'h028;
            in_ovf   = (i == 2);
            clr      = (i == 8);
        end
        @(negedge clk);
        in_valid = 1'b0; in_ovf = 1'b0; clr = 1'b0;
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_ready", 32'(in_ready),  32'd1);
        send_frame(9'h010, 9'h010, -1);
        check_result("after_clr", 8'h40, 1'b0, 1'b0);
        handshake("after_clr");

        // Reset while a result is pending discards it.
        send_frame(9'h028, 9'h028, 3);
        check_result("pre_rst", 8'h7F, 1'b1, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_out_ready", 32'(in_ready),  32'd1);
        send_frame(9'h010, 9'h010, -1);
        check_result("after_rst", 8'h40, 1'b0, 1'b0);
        handshake("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
